// File: rtl/anim_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : anim_sequencer
// Desc     : Frame sequencer for the 7-segment animation engine. The optional
//            ANIM_REVERSE_EN macro adds the `dir` input for reverse stepping.
// Revision : 1.0 - initial release
//==============================================================================
module anim_sequencer #(
  parameter int MIN_SHIFT = 16,
  parameter int DIV_W     = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] animation,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       step,
  input  logic [4:0] limit,
`ifdef ANIM_REVERSE_EN
  input  logic       dir,
`endif
  output logic [3:0] anim_sel,
  output logic [4:0] frame,
  output logic       blank,
  output logic       frame_tick,
  output logic       cycle_done
);

  localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_cnt, w_cnt_nxt, w_term;
  logic              r_step_q, w_step_rise;
  logic              w_counting, w_tick, w_keep_cnt;
  logic [5:0]        w_inc;
  logic [4:0]        w_adv_frame;
  logic              w_adv_wrap;
  logic [3:0]        w_anim_nxt;
  logic [4:0]        w_frame_nxt;
  logic              w_tick_nxt, w_done_nxt, w_blank_nxt;

  // Prescaler: terminal count follows speed combinationally, so a shorter
  // period takes effect at once and an over-range count simply restarts.
  always_comb begin
    w_term      = (c_one << (MIN_SHIFT + int'(speed))) - c_one;
    w_counting  = (r_state == RUN) || (r_state == BLANK);
    w_tick      = w_counting && (r_cnt == w_term);
    w_keep_cnt  = w_counting && ((w_state_nxt == RUN) || (w_state_nxt == BLANK))
                  && (r_cnt < w_term);
    w_cnt_nxt   = w_keep_cnt ? (r_cnt + c_one) : '0;
    w_step_rise = step & ~r_step_q;
  end

  always_comb begin
    w_inc       = {1'b0, frame} + 6'd1;
    w_adv_frame = w_inc[4:0];
    w_adv_wrap  = 1'b0;
    if (w_inc >= {1'b0, limit}) begin
      w_adv_frame = '0;
      w_adv_wrap  = 1'b1;
    end
`ifdef ANIM_REVERSE_EN
    if (dir) begin
      w_adv_frame = frame - 5'd1;
      w_adv_wrap  = (frame == 5'd1);
      if ((limit <= 5'd1) || (frame >= limit)) begin
        w_adv_frame = '0;
        w_adv_wrap  = 1'b1;
      end else if (frame == 5'd0) begin
        w_adv_frame = limit - 5'd1;
        w_adv_wrap  = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_anim_nxt  = anim_sel;
    w_frame_nxt = frame;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (!ena) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
          w_anim_nxt  = animation;
          w_frame_nxt = '0;
        end
        RUN: begin
          if (w_tick) begin
            // A pending animation switch outranks the advance and any wrap.
            if (animation != anim_sel) begin
              w_state_nxt = BLANK;
            end else begin
              w_frame_nxt = w_adv_frame;
              w_tick_nxt  = 1'b1;
              w_done_nxt  = w_adv_wrap;
              if (pause) w_state_nxt = HOLD;
            end
          end else if (pause) begin
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (w_step_rise) begin
            w_frame_nxt = w_adv_frame;
            w_tick_nxt  = 1'b1;
            w_done_nxt  = w_adv_wrap;
          end
          if (!pause) w_state_nxt = RUN;
        end
        BLANK: begin
          if (w_tick) begin
            w_state_nxt = RUN;
            w_anim_nxt  = animation;
            w_frame_nxt = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    w_blank_nxt = !((w_state_nxt == RUN) || (w_state_nxt == HOLD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_step_q   <= 1'b0;
      anim_sel   <= '0;
      frame      <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_step_q   <= step;
      anim_sel   <= w_anim_nxt;
      frame      <= w_frame_nxt;
      blank      <= w_blank_nxt;
      frame_tick <= w_tick_nxt;
      cycle_done <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_anim_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_anim_sequencer
// Desc     : Scoreboard bench for anim_sequencer (MIN_SHIFT=2); reverse phase
//            is built only with ANIM_REVERSE_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_anim_sequencer;

  localparam int MS = 2;
  localparam int DW = 10;

  logic       clk = 1'b0;
  logic       rst, ena, pause, step, force_zero;
  logic [3:0] animation;
  logic [2:0] speed;
  logic [4:0] limit;
  logic [3:0] anim_sel;
  logic [4:0] frame;
  logic       blank, frame_tick, cycle_done;
`ifdef ANIM_REVERSE_EN
  logic       dir;
`endif

  always #5 clk = ~clk;

  // Stand-in for the limit lookup table.
  function automatic logic [4:0] lut(input logic [3:0] a);
    case (a)
      4'd0:    lut = 5'd10;
      4'd1:    lut = 5'd12;
      4'd5:    lut = 5'd6;
      4'd7:    lut = 5'd2;
      default: lut = 5'd8;
    endcase
  endfunction

  assign limit = force_zero ? 5'd0 : lut(anim_sel);

  anim_sequencer #(.MIN_SHIFT(MS), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .animation  (animation),
    .speed      (speed),
    .pause      (pause),
    .step       (step),
    .limit      (limit),
`ifdef ANIM_REVERSE_EN
    .dir        (dir),
`endif
    .anim_sel   (anim_sel),
    .frame      (frame),
    .blank      (blank),
    .frame_tick (frame_tick),
    .cycle_done (cycle_done)
  );

  typedef struct {
    logic [3:0] anim;
    logic [4:0] frame;
    logic       done;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_tick = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [4:0] f, input logic d, input int g);
    exp_t x;
    x.anim = a; x.frame = f; x.done = d; x.gap = g;
    sbq.push_back(x);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic stop_run();
    ena = 1'b0;
    cycles(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_anim_sel"},   anim_sel,   0);
    chk({tag, "_frame"},      frame,      0);
    chk({tag, "_blank"},      blank,      1);
    chk({tag, "_frame_tick"}, frame_tick, 0);
    chk({tag, "_cycle_done"}, cycle_done, 0);
  endtask

  // Monitor: every frame_tick consumes one expected entry.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_tick === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("tick_unexpected", frame_tick, 0);
      end else begin
        e = sbq.pop_front();
        chk("tick_anim",  anim_sel,   e.anim);
        chk("tick_frame", frame,      e.frame);
        chk("tick_done",  cycle_done, e.done);
        if (e.gap != 0) chk("tick_gap", cyc - last_tick, e.gap);
      end
      last_tick = cyc;
    end else if (cycle_done !== 1'b0) begin
      chk("done_without_tick", cycle_done, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, queue=%0d", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst = 1'b1; ena = 1'b0; animation = 4'd7; speed = 3'd0;
    pause = 1'b0; step = 1'b0; force_zero = 1'b0;
`ifdef ANIM_REVERSE_EN
    dir = 1'b0;
`endif
    cycles(3);
    chk_reset_vals("rst");
    rst = 1'b0;
    cycles(1);

    // Rate and wrap: limit 2, tick every 4 clk.
    ena = 1'b1;
    cycles(1);
    chk("run_anim_sel", anim_sel, 7);
    chk("run_blank",    blank,    0);
    chk("run_frame",    frame,    0);
    push(7, 1, 0, 0); push(7, 0, 1, 4); push(7, 1, 0, 4); push(7, 0, 1, 4);
    drain(40);
    stop_run();

    // Rate select: speed 3 -> 32 clk per frame, limit 10.
    animation = 4'd0; speed = 3'd3; ena = 1'b1;
    for (int i = 1; i <= 10; i++) push(0, 5'(i % 10), i == 10, (i == 1) ? 0 : 32);
    drain(400);
    stop_run();

    // Switch with one blank frame.
    speed = 3'd0; animation = 4'd0; ena = 1'b1;
    for (int i = 1; i <= 5; i++) push(0, 5'(i), 0, (i == 1) ? 0 : 4);
    drain(40);
    animation = 4'd1;
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (blank === 1'b1) nb++;
    end
    chk("blank_len",        nb,       4);
    chk("switch_anim_sel",  anim_sel, 1);
    chk("switch_frame",     frame,    0);
    push(1, 1, 0, 12);
    for (int i = 2; i <= 11; i++) push(1, 5'(i), 0, 4);
    push(1, 0, 1, 4);
    drain(80);
    stop_run();

    // Pause and single step.
    animation = 4'd0; ena = 1'b1;
    push(0, 1, 0, 0); push(0, 2, 0, 4); push(0, 3, 0, 4);
    drain(40);
    pause = 1'b1;
    cycles(3);
    chk("hold_frame", frame, 3);
    chk("hold_blank", blank, 0);
    for (int s = 4; s <= 6; s++) begin
      push(0, 5'(s), 0, 0);
      step = 1'b1; cycles(1);
      step = 1'b0; cycles(3);
    end
    push(0, 7, 0, 0);
    step = 1'b1; cycles(10);
    step = 1'b0; cycles(3);
    animation = 4'd1;
    cycles(6);
    chk("hold_q_empty",     sbq.size(), 0);
    chk("hold_anim_sel",    anim_sel,   0);
    chk("hold_frame_after", frame,      7);
    chk("hold_blank_after", blank,      0);
    pause = 1'b0;
    push(1, 1, 0, 0);
    drain(40);
    stop_run();

    // Degenerate limit.
    animation = 4'd0; force_zero = 1'b1; ena = 1'b1;
    push(0, 0, 1, 0); push(0, 0, 1, 4); push(0, 0, 1, 4); push(0, 0, 1, 4);
    drain(40);
    stop_run();
    force_zero = 1'b0;

    // Asynchronous reset in the middle of BLANK.
    animation = 4'd7; ena = 1'b1;
    push(7, 1, 0, 0);
    drain(40);
    animation = 4'd0;
    cycles(5);
    chk("mid_blank",    blank,    1);
    chk("mid_anim_sel", anim_sel, 7);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    ena = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);

`ifdef ANIM_REVERSE_EN
    // Reverse stepping with limit 6.
    dir = 1'b1; animation = 4'd5; ena = 1'b1;
    push(5, 5, 0, 0);
    for (int i = 4; i >= 1; i--) push(5, 5'(i), 0, 4);
    push(5, 0, 1, 4);
    drain(60);
    stop_run();
`endif

    cycles(2);
    chk("final_q_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
